bcd_updown_counter_mod: RTL and testbench

Parametrised, loadable, up/down BCD counter with a configurable digit count and modulus. It generalises the fixed mod-24, mod-60 and mod-100 loadable up and down counters into one block. It sits behind the tick dividers (usec/msec/sec/min strobes) in the watch, stopwatch and cook-timer datapaths. A registered carry/borrow pulse lets instances cascade (sec → min → hour) without extra edge detectors.

---
 rtl/bcd_cnt_pkg.sv | 27 ++
 rtl/bcd_updown_counter_mod_digit.sv | 48 ++++
 rtl/bcd_updown_counter_mod.sv | 167 ++++++++++++++++
 tb/tb_bcd_updown_counter_mod.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_cnt_pkg.sv
// Shared definitions for the BCD up/down counter.
//   bcd_digit_t    : one BCD digit (4 bits, legal values 0..9)
//   BCD_MAX_DIGITS : widest counter supported
//   BCD_DIGIT_MAX  : largest legal digit value
//   to_bcd()       : integer to packed BCD, intended for elaboration-time constants only
package bcd_cnt_pkg;

  localparam int BCD_MAX_DIGITS = 4;
  localparam int BCD_DIGIT_MAX  = 9;

  typedef logic [3:0] bcd_digit_t;

  // Digit 0 lands in bits [3:0]. Used only to build localparams, so the
  // divide/modulo never becomes hardware.
  function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int value);
    logic [4*BCD_MAX_DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_mod_digit.sv
// One BCD digit of the up/down counter.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset (digit -> 0)
//   load           : overwrite digit with load_digit (has priority over step_in)
//   load_digit     : value to load
//   step_in        : carry-in (up) / borrow-in (down) from the lower digit,
//                    or the count strobe for digit 0
//   up             : 1 = increment, 0 = decrement
//   digit          : registered digit value
//   step_out       : combinational carry/borrow to the next digit
// Terminal and wrap decisions live in the top level; this cell only ripples.
module bcd_digit_cell
  import bcd_cnt_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       step_in,
  input  logic       up,
  output bcd_digit_t digit,
  output logic       step_out
);

  logic at_top;
  logic at_bottom;

  assign at_top    = (digit == 4'(BCD_DIGIT_MAX));
  assign at_bottom = (digit == 4'd0);

  // 9 -> 0 on increment and 0 -> 9 on decrement pass the step upward.
  assign step_out = step_in && (up ? at_top : at_bottom);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_digit;
    end else if (step_in) begin
      if (up) begin
        digit <= at_top ? 4'd0 : digit + 4'd1;
      end else begin
        digit <= at_bottom ? 4'(BCD_DIGIT_MAX) : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter_mod.sv
// Loadable up/down BCD counter, DIGITS digits, counting 0..MODULO-1.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset (count/carry/done -> 0)
//   tick           : single-cycle count strobe
//   up             : direction sampled with tick (1 = up, 0 = down)
//   load           : synchronous load, wins over tick; out-of-range values clamp to MODULO-1
//   load_value     : BCD value to load, digit 0 in [3:0]
//   count          : registered BCD count, digit 0 in [3:0]
//   carry          : registered one-cycle pulse on wrap/borrow (or arrival at terminal)
//   done           : terminal-hold flag, 0 unless BCD_CNT_STOP_AT_TERMINAL_EN is defined
// Build option:
//   BCD_CNT_STOP_AT_TERMINAL_EN : timer mode -- stop at MODULO-1 (up) or 0 (down),
//                                 raise done, never wrap.
// Handshake: tick and load are plain strobes, one event per high cycle, no
// back-pressure; every high cycle is acted on.
module bcd_updown_counter_mod
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MODULO = 60
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic                done
);

  localparam int W = 4 * DIGITS;

  generate
    if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS || MODULO < 2 || MODULO > 10 ** DIGITS) begin : g_bad_params
      $error("bcd_updown_counter_mod: illegal DIGITS/MODULO combination");
    end
  endgenerate

  localparam logic [4*BCD_MAX_DIGITS-1:0] MAX_FULL = to_bcd(MODULO - 1);
  localparam logic [W-1:0]                MAX_BCD  = MAX_FULL[W-1:0];

  logic         at_max;
  logic         at_zero;
  logic         digits_ok;
  logic         load_ok;
  logic         cell_load;
  logic [W-1:0] cell_value;
  logic [DIGITS:0] step_chain;
  logic         carry_d;
  logic         unused_top_ripple;

  assign at_max  = (count == MAX_BCD);
  assign at_zero = (count == '0);

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'(BCD_DIGIT_MAX)) digits_ok = 1'b0;
    end
  end

  // With every digit in 0..9, packed BCD orders the same way as the number
  // it encodes, so a plain unsigned compare against MAX_BCD is a range check.
  assign load_ok = digits_ok && (load_value <= MAX_BCD);

`ifdef BCD_CNT_STOP_AT_TERMINAL_EN
  localparam logic [4*BCD_MAX_DIGITS-1:0] PRE_FULL = to_bcd(MODULO - 2);
  localparam logic [W-1:0]                PRE_BCD  = PRE_FULL[W-1:0];
  localparam logic [W-1:0]                ONE_BCD  = W'(1);

  logic done_d;
  logic at_pre_max;
  logic at_one;

  assign at_pre_max = (count == PRE_BCD);
  assign at_one     = (count == ONE_BCD);

  always_comb begin
    cell_load     = 1'b0;
    cell_value    = '0;
    step_chain[0] = 1'b0;
    carry_d       = 1'b0;
    done_d        = done;
    if (load) begin
      cell_load  = 1'b1;
      cell_value = load_ok ? load_value : MAX_BCD;
      done_d     = 1'b0;
    end else if (tick) begin
      if (up ? at_max : at_zero) begin
        // Already sitting on the terminal for this direction: hold.
        done_d = 1'b1;
      end else begin
        step_chain[0] = 1'b1;
        done_d        = 1'b0;
        if (up ? at_pre_max : at_one) begin
          // This tick arrives at the terminal.
          done_d  = 1'b1;
          carry_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else begin
      done <= done_d;
    end
  end
`else
  always_comb begin
    cell_load     = 1'b0;
    cell_value    = '0;
    step_chain[0] = 1'b0;
    carry_d       = 1'b0;
    if (load) begin
      cell_load  = 1'b1;
      cell_value = load_ok ? load_value : MAX_BCD;
    end else if (tick) begin
      // Wraps are forced as loads so the digit cells never need to know MODULO.
      if (up && at_max) begin
        cell_load = 1'b1;
        carry_d   = 1'b1;
      end else if (!up && at_zero) begin
        cell_load  = 1'b1;
        cell_value = MAX_BCD;
        carry_d    = 1'b1;
      end else begin
        step_chain[0] = 1'b1;
      end
    end
  end

  assign done = 1'b0;
`endif

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_cell u_cell (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cell_load),
        .load_digit (cell_value[4*i +: 4]),
        .step_in    (step_chain[i]),
        .up         (up),
        .digit      (count[4*i +: 4]),
        .step_out   (step_chain[i+1])
      );
    end
  endgenerate

  // A ripple out of the top digit can only happen at the terminal, which is
  // handled above as a wrap/hold, so it is never consumed.
  assign unused_top_ripple = step_chain[DIGITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry <= 1'b0;
    end else begin
      carry <= carry_d;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_mod.sv
// Directed bench for bcd_updown_counter_mod: four instances with different
// DIGITS/MODULO share one stimulus bus; each test loads its own start value
// and checks only the instance it is about.
module tb_bcd_updown_counter_mod;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        tick;
  logic        up;
  logic        load;
  logic [11:0] lv;

  logic [7:0]  cnt60, cnt24, cnt100;
  logic [11:0] cnt1k;
  logic        c60, c24, c100, c1k;
  logic        d60, d24, d100, d1k;

  bcd_updown_counter_mod #(.DIGITS(2), .MODULO(60)) u_m60 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .up(up), .load(load),
    .load_value(lv[7:0]), .count(cnt60), .carry(c60), .done(d60));
  bcd_updown_counter_mod #(.DIGITS(2), .MODULO(24)) u_m24 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .up(up), .load(load),
    .load_value(lv[7:0]), .count(cnt24), .carry(c24), .done(d24));
  bcd_updown_counter_mod #(.DIGITS(2), .MODULO(100)) u_m100 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .up(up), .load(load),
    .load_value(lv[7:0]), .count(cnt100), .carry(c100), .done(d100));
  bcd_updown_counter_mod #(.DIGITS(3), .MODULO(1000)) u_m1k (
    .clk(clk), .reset_n(reset_n), .tick(tick), .up(up), .load(load),
    .load_value(lv), .count(cnt1k), .carry(c1k), .done(d1k));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1'b1;
    lv   = v;
    step();
    load = 1'b0;
  endtask

  logic [7:0] exp8;

  initial begin
    reset_n = 1'b0;
    tick = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt60", {8'h0, cnt60}, 16'h0000);
    check("rst_carry60", {15'h0, c60}, 16'h0000);
    check("rst_done60", {15'h0, d60}, 16'h0000);
    check("rst_cnt1k", {4'h0, cnt1k}, 16'h0000);
    reset_n = 1'b1;
    step();

    // Load clamping on the mod-24 instance.
    do_load(12'h023);
    check("m24_load23", {8'h0, cnt24}, 16'h0023);
    check("m24_load_nocarry", {15'h0, c24}, 16'h0000);
    do_load(12'h02A);
    check("m24_load2A_clamp", {8'h0, cnt24}, 16'h0023);
    do_load(12'h024);
    check("m24_load24_clamp", {8'h0, cnt24}, 16'h0023);
    do_load(12'h017);
    check("m24_load17", {8'h0, cnt24}, 16'h0017);
    do_load(12'h0F0);
    check("m24_loadF0_clamp", {8'h0, cnt24}, 16'h0023);

`ifndef BCD_CNT_STOP_AT_TERMINAL_EN
    // Mod-24: 23 + up tick wraps to 00 with a single-cycle carry.
    tick = 1'b1; up = 1'b1;
    step();
    tick = 1'b0;
    check("m24_wrap_cnt", {8'h0, cnt24}, 16'h0000);
    check("m24_wrap_carry", {15'h0, c24}, 16'h0001);
    step();
    check("m24_carry_drop", {15'h0, c24}, 16'h0000);

    // Mod-60 from reset value: 60 back-to-back up ticks.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      exp_q.push_back({8'h0, 4'((i % 60) / 10), 4'((i % 60) % 10)});
    end
    tick = 1'b1; up = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      check($sformatf("m60_run_cnt%0d", i), {8'h0, cnt60}, exp_q.pop_front());
      check($sformatf("m60_run_carry%0d", i), {15'h0, c60}, (i == 60) ? 16'h1 : 16'h0);
    end
    tick = 1'b0;
    step();
    check("m60_carry_after", {15'h0, c60}, 16'h0000);
    check("m60_done_tied", {15'h0, d60}, 16'h0000);

    // Mod-100: borrow at 00, then three plain decrements.
    do_load(12'h000);
    tick = 1'b1; up = 1'b0;
    step();
    check("m100_borrow_cnt", {8'h0, cnt100}, 16'h0099);
    check("m100_borrow_carry", {15'h0, c100}, 16'h0001);
    exp8 = 8'h98;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("m100_dec%0d", i), {8'h0, cnt100}, {8'h0, exp8});
      check($sformatf("m100_dec_carry%0d", i), {15'h0, c100}, 16'h0000);
      exp8 = exp8 - 8'h01;
    end
    tick = 1'b0;

    // Load and tick together: load wins, no carry.
    load = 1'b1; lv = 12'h045; tick = 1'b1; up = 1'b1;
    step();
    load = 1'b0;
    check("m60_load_tick_cnt", {8'h0, cnt60}, 16'h0045);
    check("m60_load_tick_carry", {15'h0, c60}, 16'h0000);
    step();
    check("m60_after_load46", {8'h0, cnt60}, 16'h0046);
    step();
    check("m60_after_load47", {8'h0, cnt60}, 16'h0047);
    reset_n = 1'b0;
    #1;
    check("m60_midrun_rst_cnt", {8'h0, cnt60}, 16'h0000);
    check("m60_midrun_rst_carry", {15'h0, c60}, 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    check("m60_first_after_rst", {8'h0, cnt60}, 16'h0001);
    tick = 1'b0;

    // Three digits: 999 wraps through every digit; reset in the carry cycle.
    do_load(12'h999);
    check("m1k_load999", {4'h0, cnt1k}, 16'h0999);
    tick = 1'b1; up = 1'b1;
    step();
    tick = 1'b0;
    check("m1k_wrap_cnt", {4'h0, cnt1k}, 16'h0000);
    check("m1k_wrap_carry", {15'h0, c1k}, 16'h0001);
    #2;
    reset_n = 1'b0;
    #1;
    check("m1k_midpulse_rst_carry", {15'h0, c1k}, 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_load(12'h099);
    tick = 1'b1; up = 1'b1;
    step();
    check("m1k_ripple_up", {4'h0, cnt1k}, 16'h0100);
    check("m1k_ripple_up_carry", {15'h0, c1k}, 16'h0000);
    up = 1'b0;
    step();
    check("m1k_ripple_down", {4'h0, cnt1k}, 16'h0099);
    tick = 1'b0;
`else
    // Timer mode on mod-60: count down from 02 and stop at 00.
    do_load(12'h002);
    check("tm_load02", {8'h0, cnt60}, 16'h0002);
    check("tm_load_done", {15'h0, d60}, 16'h0000);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    tick = 1'b1; up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("tm_down_cnt%0d", i), {8'h0, cnt60}, exp_q.pop_front());
      check($sformatf("tm_down_done%0d", i), {15'h0, d60}, (i >= 1) ? 16'h1 : 16'h0);
      check($sformatf("tm_down_carry%0d", i), {15'h0, c60}, (i == 1) ? 16'h1 : 16'h0);
    end
    up = 1'b1;
    step();
    tick = 1'b0;
    check("tm_up_cnt", {8'h0, cnt60}, 16'h0001);
    check("tm_up_done", {15'h0, d60}, 16'h0000);
    check("tm_up_carry", {15'h0, c60}, 16'h0000);
`endif

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
